// File: rtl/img_line_writer.sv
// Write side of the 8-row image line buffer: stores camera rows into two BRAM
// channels (even rows on ch0, odd rows on ch1), then publishes a {row_id, row_h}
// descriptor to the reader once the row's data has reached BRAM. A credit
// counter tracks free row slots so a slot still held by the reader is never
// overwritten.
module img_line_writer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        frst_n,
  input  logic [23:0] i_pix_data,
  input  logic        i_pix_vld,
  input  logic        i_pix_sof,
  input  logic        i_pix_eol,
  output logic        o_pix_rdy,
  output logic [11:0] o_ch0_waddr,
  output logic [31:0] o_ch0_wdata,
  output logic        o_ch0_we,
  output logic [11:0] o_ch1_waddr,
  output logic [31:0] o_ch1_wdata,
  output logic        o_ch1_we,
  output logic [11:0] o_8row_wdata,
  output logic        o_8row_we,
  input  logic        i_8row_full,
  input  logic        i_8row_free,
  input  logic        i_err_clr,
  output logic        o_frame_done,
  output logic [2:0]  o_err
);

  localparam logic [9:0] COL_LAST   = 10'(IMG_W - 1);
  localparam logic [8:0] ROW_LAST   = 9'(IMG_H - 1);
  localparam logic [3:0] CREDIT_MAX = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE,
    S_COMMIT,
    S_WAIT_SLOT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  credit_q, credit_d;
  logic [2:0]  row_id_q, row_id_d;
  logic [8:0]  row_h_q, row_h_d;
  logic [9:0]  col_q, col_d;
  logic        drop_q, drop_d;
  logic [2:0]  err_q, err_d;

  // BRAM write stage, one cycle behind pixel acceptance
  logic        ch0_we_p1_q, ch0_we_p1_d;
  logic        ch1_we_p1_q, ch1_we_p1_d;
  logic [11:0] waddr_p1_q, waddr_p1_d;
  logic [31:0] wdata_p1_q, wdata_p1_d;

  // Descriptor push, registered so it trails the row's last BRAM write
  logic        desc_we_q, desc_we_d;
  logic [11:0] desc_q, desc_d;
  logic        frame_done_q, frame_done_d;

  logic        pix_rdy;
  logic        claim;
  logic        wr_en;
  logic        push;
  logic [9:0]  wr_col;
  logic [2:0]  err_set;

  // Next-state, slot credit, error and write/descriptor staging logic
  always_comb begin
    state_d  = state_q;
    row_id_d = row_id_q;
    row_h_d  = row_h_q;
    col_d    = col_q;
    drop_d   = drop_q;
    credit_d = credit_q;
    pix_rdy  = 1'b0;
    claim    = 1'b0;
    wr_en    = 1'b0;
    wr_col   = col_q;
    push     = 1'b0;
    err_set  = 3'b000;

    case (state_q)
      S_IDLE: begin
        // Only a SOF needs a slot; stray mid-frame pixels are swallowed.
        pix_rdy = ~i_pix_sof | (credit_q != 4'd0);
        if (i_pix_vld && pix_rdy && i_pix_sof) begin
          row_h_d = 9'd0;
          wr_en   = 1'b1;
          wr_col  = 10'd0;
          col_d   = 10'd1;
          drop_d  = 1'b0;
          claim   = 1'b1;
          state_d = S_LINE;
        end
      end

      S_LINE: begin
        pix_rdy = 1'b1;
        if (i_pix_vld) begin
          if (drop_q && !i_pix_sof) begin
            // Tail of an over-long row: discard up to and including its EOL.
            err_set[1] = 1'b1;
            if (i_pix_eol) drop_d = 1'b0;
          end else begin
            // SOF restarts the frame in the slot already claimed.
            wr_en  = 1'b1;
            wr_col = i_pix_sof ? 10'd0 : col_q;
            col_d  = wr_col + 10'd1;
            if (i_pix_sof) begin
              row_h_d = 9'd0;
              drop_d  = 1'b0;
            end
            if (i_pix_eol || wr_col == COL_LAST) begin
              state_d = S_COMMIT;
              if (wr_col != COL_LAST) err_set[0] = 1'b1;
              if (!i_pix_eol) drop_d = 1'b1;
            end
          end
        end
      end

      S_COMMIT: begin
        if (!i_8row_full) begin
          push     = 1'b1;
          row_id_d = row_id_q + 3'd1;
          col_d    = 10'd0;
          if (row_h_q == ROW_LAST) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            row_h_d = row_h_q + 9'd1;
            // A slot freed this very cycle is usable immediately.
            if (credit_q != 4'd0 || i_8row_free) begin
              claim   = 1'b1;
              state_d = S_LINE;
            end else begin
              state_d = S_WAIT_SLOT;
            end
          end
        end
      end

      S_WAIT_SLOT: begin
        if (credit_q != 4'd0) begin
          claim   = 1'b1;
          state_d = S_LINE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    case ({claim, i_8row_free})
      2'b10: credit_d = credit_q - 4'd1;
      2'b01: begin
        if (credit_q == CREDIT_MAX) err_set[2] = 1'b1;
        else                        credit_d = credit_q + 4'd1;
      end
      default: credit_d = credit_q;
    endcase

    // A new error event outranks a simultaneous clear.
    err_d = (i_err_clr ? 3'b000 : err_q) | err_set;

    ch0_we_p1_d  = wr_en & ~row_id_q[0];
    ch1_we_p1_d  = wr_en &  row_id_q[0];
    waddr_p1_d   = wr_en ? {row_id_q[2:1], wr_col} : waddr_p1_q;
    wdata_p1_d   = wr_en ? {8'h00, i_pix_data} : wdata_p1_q;
    desc_we_d    = push;
    desc_d       = push ? {row_id_q, row_h_q} : desc_q;
    frame_done_d = desc_we_q && (desc_q[8:0] == ROW_LAST);
  end

  // Control state register
  always_ff @(posedge clk or negedge frst_n) begin
    if (!frst_n) begin
      state_q  <= S_IDLE;
      credit_q <= CREDIT_MAX;
      row_id_q <= 3'd0;
      row_h_q  <= 9'd0;
      col_q    <= 10'd0;
      drop_q   <= 1'b0;
      err_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      row_id_q <= row_id_d;
      row_h_q  <= row_h_d;
      col_q    <= col_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  // BRAM write and descriptor output registers
  always_ff @(posedge clk or negedge frst_n) begin
    if (!frst_n) begin
      ch0_we_p1_q  <= 1'b0;
      ch1_we_p1_q  <= 1'b0;
      waddr_p1_q   <= 12'd0;
      wdata_p1_q   <= 32'd0;
      desc_we_q    <= 1'b0;
      desc_q       <= 12'd0;
      frame_done_q <= 1'b0;
    end else begin
      ch0_we_p1_q  <= ch0_we_p1_d;
      ch1_we_p1_q  <= ch1_we_p1_d;
      waddr_p1_q   <= waddr_p1_d;
      wdata_p1_q   <= wdata_p1_d;
      desc_we_q    <= desc_we_d;
      desc_q       <= desc_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Ready is combinational; masking with the reset keeps it low while held in reset.
  assign o_pix_rdy    = pix_rdy & frst_n;
  assign o_ch0_we     = ch0_we_p1_q;
  assign o_ch0_waddr  = waddr_p1_q;
  assign o_ch0_wdata  = wdata_p1_q;
  assign o_ch1_we     = ch1_we_p1_q;
  assign o_ch1_waddr  = waddr_p1_q;
  assign o_ch1_wdata  = wdata_p1_q;
  assign o_8row_we    = desc_we_q;
  assign o_8row_wdata = desc_q;
  assign o_frame_done = frame_done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_img_line_writer.sv
// Directed testbench for img_line_writer.
module tb_img_line_writer;

  logic        clk;
  logic        frst_n;
  logic [23:0] i_pix_data;
  logic        i_pix_vld;
  logic        i_pix_sof;
  logic        i_pix_eol;
  logic        o_pix_rdy;
  logic [11:0] o_ch0_waddr;
  logic [31:0] o_ch0_wdata;
  logic        o_ch0_we;
  logic [11:0] o_ch1_waddr;
  logic [31:0] o_ch1_wdata;
  logic        o_ch1_we;
  logic [11:0] o_8row_wdata;
  logic        o_8row_we;
  logic        i_8row_full;
  logic        i_8row_free;
  logic        i_err_clr;
  logic        o_frame_done;
  logic [2:0]  o_err;

  int errors = 0;
  int checks = 0;
  int last_stall;
  int cyc = 0;

  typedef struct packed {
    logic        ch;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         wr_log[$];
  logic [11:0] desc_log[$];
  int          desc_cyc[$];
  int          done_cnt;

  img_line_writer #(.IMG_W(640), .IMG_H(480)) dut (
    .clk(clk), .frst_n(frst_n),
    .i_pix_data(i_pix_data), .i_pix_vld(i_pix_vld),
    .i_pix_sof(i_pix_sof), .i_pix_eol(i_pix_eol), .o_pix_rdy(o_pix_rdy),
    .o_ch0_waddr(o_ch0_waddr), .o_ch0_wdata(o_ch0_wdata), .o_ch0_we(o_ch0_we),
    .o_ch1_waddr(o_ch1_waddr), .o_ch1_wdata(o_ch1_wdata), .o_ch1_we(o_ch1_we),
    .o_8row_wdata(o_8row_wdata), .o_8row_we(o_8row_we),
    .i_8row_full(i_8row_full), .i_8row_free(i_8row_free),
    .i_err_clr(i_err_clr), .o_frame_done(o_frame_done), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: logs BRAM writes, descriptor pushes and frame_done pulses.
  always @(negedge clk) begin
    if (!frst_n) begin
      wr_log.delete();
      desc_log.delete();
      desc_cyc.delete();
      done_cnt <= 0;
    end else begin
      if (o_ch0_we) wr_log.push_back({1'b0, o_ch0_waddr, o_ch0_wdata, cyc});
      if (o_ch1_we) wr_log.push_back({1'b1, o_ch1_waddr, o_ch1_wdata, cyc});
      if (o_8row_we) begin
        desc_log.push_back(o_8row_wdata);
        desc_cyc.push_back(cyc);
      end
      if (o_frame_done) done_cnt <= done_cnt + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pv(input int i);
    return 24'(i * 37 + 'h102030);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    frst_n = 1'b0;
    i_pix_data = '0; i_pix_vld = 1'b0; i_pix_sof = 1'b0; i_pix_eol = 1'b0;
    i_8row_full = 1'b0; i_8row_free = 1'b0; i_err_clr = 1'b0;
    repeat (2) @(negedge clk);
    frst_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one pixel and holds it until accepted; records stall cycles.
  task automatic pix(input logic [23:0] d, input logic sof, input logic eol);
    int n;
    n = 0;
    i_pix_data = d; i_pix_sof = sof; i_pix_eol = eol; i_pix_vld = 1'b1;
    #1;
    while (o_pix_rdy !== 1'b1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    last_stall = n;
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL pix_accept_timeout: rdy=%b required 1", o_pix_rdy);
    end
    @(negedge clk);
    i_pix_vld = 1'b0; i_pix_sof = 1'b0; i_pix_eol = 1'b0;
  endtask

  task automatic pulse_free();
    i_8row_free = 1'b1;
    @(negedge clk);
    i_8row_free = 1'b0;
  endtask

  task automatic test_reset();
    frst_n = 1'b0;
    i_pix_data = '0; i_pix_vld = 1'b0; i_pix_sof = 1'b1; i_pix_eol = 1'b0;
    i_8row_full = 1'b0; i_8row_free = 1'b0; i_err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({o_pix_rdy, o_ch0_waddr, o_ch0_wdata, o_ch0_we, o_ch1_waddr, o_ch1_wdata,
         o_ch1_we, o_8row_wdata, o_8row_we, o_frame_done, o_err} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero, required all 0");
    end
    @(negedge clk);
    frst_n = 1'b1;
    #1;
    checks++;
    if (o_pix_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_rdy_sof: got %b required 1", o_pix_rdy);
    end
    checks++;
    if (dut.credit_q !== 4'd8) begin
      errors++; $display("FAIL reset_credit: got %0d required 8", dut.credit_q);
    end
    i_pix_sof = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_row();
    int bad, n0, dly;
    do_reset();
    for (int i = 0; i < 640; i++) pix(pv(i), i == 0, i == 639);
    #1;
    checks++;
    if (dut.credit_q !== 4'd7) begin
      errors++; $display("FAIL row_credit: got %0d required 7", dut.credit_q);
    end
    pix(pv(1000), 1'b0, 1'b0);
    checks++;
    if (last_stall !== 1) begin
      errors++; $display("FAIL row_commit_stall: got %0d cycles required 1", last_stall);
    end
    wait_cyc(3);
    bad = 0; n0 = 0;
    foreach (wr_log[k]) begin
      if (wr_log[k].ch == 1'b0) begin
        if (wr_log[k].addr !== 12'(n0) || wr_log[k].data !== {8'h00, pv(n0)}) bad++;
        n0++;
      end
    end
    checks++;
    if (n0 !== 640) begin
      errors++; $display("FAIL row_ch0_count: got %0d required 640", n0);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL row_ch0_addr_data: got %0d bad writes required 0", bad);
    end
    checks++;
    if (desc_log.size() !== 1) begin
      errors++; $display("FAIL row_desc_count: got %0d required 1", desc_log.size());
    end else begin
      checks++;
      if (desc_log[0] !== {3'd0, 9'd0}) begin
        errors++; $display("FAIL row_desc_data: got %h required 000", desc_log[0]);
      end
      dly = (wr_log.size() >= 640) ? desc_cyc[0] - wr_log[639].cyc : -1;
      checks++;
      if (dly < 1) begin
        errors++; $display("FAIL row_desc_after_write: got %0d cycles required >=1", dly);
      end
    end
    checks++;
    if (wr_log.size() != 641 || {wr_log[640].ch, wr_log[640].addr} !== {1'b1, 12'h000}) begin
      errors++; $display("FAIL row1_first_write: got size %0d required ch1 addr 000", wr_log.size());
    end
  endtask

  task automatic test_full_frame();
    int bad;
    do_reset();
    for (int r = 0; r < 480; r++) begin
      if (r >= 8) pulse_free();
      pix(pv(2 * r), r == 0, 1'b0);
      pix(pv(2 * r + 1), 1'b0, 1'b1);
    end
    wait_cyc(4);
    checks++;
    if (desc_log.size() !== 480) begin
      errors++; $display("FAIL frame_desc_count: got %0d required 480", desc_log.size());
    end
    bad = 0;
    foreach (desc_log[k]) if (desc_log[k] !== {3'(k), 9'(k)}) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL frame_desc_seq: got %0d bad required 0", bad);
    end
    checks++;
    if (desc_log.size() == 0 || desc_log[desc_log.size() - 1] !== {3'd7, 9'd479}) begin
      errors++; $display("FAIL frame_last_desc: required %h", {3'd7, 9'd479});
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL frame_done_count: got %0d required 1", done_cnt);
    end
    checks++;
    if ({wr_log[2].ch, wr_log[2].addr} !== {1'b1, 12'h000}) begin
      errors++; $display("FAIL frame_row1_addr: got %b/%h required 1/000", wr_log[2].ch, wr_log[2].addr);
    end
    checks++;
    if ({wr_log[4].ch, wr_log[4].addr} !== {1'b0, 12'h400}) begin
      errors++; $display("FAIL frame_row2_addr: got %b/%h required 0/400", wr_log[4].ch, wr_log[4].addr);
    end
    checks++;
    if ({wr_log[14].ch, wr_log[14].addr} !== {1'b1, 12'hC00}) begin
      errors++; $display("FAIL frame_row7_addr: got %b/%h required 1/c00", wr_log[14].ch, wr_log[14].addr);
    end
  endtask

  task automatic test_no_free();
    int bad;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      pix(pv(r), r == 0, 1'b0);
      pix(pv(r + 50), 1'b0, 1'b1);
    end
    wait_cyc(3);
    #1;
    checks++;
    if (desc_log.size() !== 8 || o_pix_rdy !== 1'b0) begin
      errors++; $display("FAIL nofree_wait: got desc %0d rdy %b required 8/0", desc_log.size(), o_pix_rdy);
    end
    checks++;
    if (dut.credit_q !== 4'd0) begin
      errors++; $display("FAIL nofree_credit: got %0d required 0", dut.credit_q);
    end
    @(negedge clk);
    pulse_free();
    pix(pv(8), 1'b0, 1'b0);
    pix(pv(9), 1'b0, 1'b1);
    wait_cyc(3);
    checks++;
    if (desc_log.size() !== 9) begin
      errors++; $display("FAIL nofree_resume_one: got %0d required 9", desc_log.size());
    end
    i_pix_data = pv(10); i_pix_vld = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (o_pix_rdy !== 1'b0) bad++;
    end
    i_pix_vld = 1'b0;
    checks++;
    if (bad !== 0 || wr_log.size() !== 18) begin
      errors++; $display("FAIL nofree_second_blocked: got rdy-high %0d writes %0d required 0/18", bad, wr_log.size());
    end
  endtask

  task automatic test_fifo_full();
    int bad, c_acc;
    do_reset();
    i_8row_full = 1'b1;
    pix(pv(0), 1'b1, 1'b0);
    pix(pv(1), 1'b0, 1'b1);
    c_acc = cyc;
    bad = 0;
    repeat (5) begin
      #1;
      if (o_pix_rdy !== 1'b0 || o_8row_we !== 1'b0 || desc_log.size() != 0) bad++;
      @(negedge clk);
    end
    i_8row_full = 1'b0;
    wait_cyc(3);
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL full_hold: got %0d bad cycles required 0", bad);
    end
    checks++;
    if (desc_log.size() !== 1) begin
      errors++; $display("FAIL full_desc_count: got %0d required 1", desc_log.size());
    end else begin
      checks++;
      if (desc_cyc[0] - c_acc !== 6) begin
        errors++; $display("FAIL full_push_delay: got %0d required 6", desc_cyc[0] - c_acc);
      end
      checks++;
      if (desc_log[0] !== 12'h000) begin
        errors++; $display("FAIL full_desc_data: got %h required 000", desc_log[0]);
      end
    end
  endtask

  task automatic test_short_long();
    int bad, n1;
    do_reset();
    for (int i = 0; i < 100; i++) pix(pv(i), i == 0, i == 99);
    wait_cyc(2);
    checks++;
    if (o_err !== 3'b001) begin
      errors++; $display("FAIL short_err: got %b required 001", o_err);
    end
    checks++;
    if (desc_log.size() !== 1 || desc_log[0] !== 12'h000) begin
      errors++; $display("FAIL short_desc: got size %0d required 1 with 000", desc_log.size());
    end
    for (int i = 0; i < 700; i++) pix(pv(i + 300), 1'b0, i == 699);
    wait_cyc(2);
    bad = 0; n1 = 0;
    foreach (wr_log[k]) begin
      if (wr_log[k].ch == 1'b1) begin
        if (wr_log[k].addr !== 12'(n1) || wr_log[k].data !== {8'h00, pv(n1 + 300)}) bad++;
        n1++;
      end
    end
    checks++;
    if (n1 !== 640 || bad !== 0 || wr_log.size() !== 740) begin
      errors++; $display("FAIL long_writes: got ch1 %0d bad %0d total %0d required 640/0/740", n1, bad, wr_log.size());
    end
    checks++;
    if (desc_log.size() !== 2 || desc_log[1] !== {3'd1, 9'd1}) begin
      errors++; $display("FAIL long_desc: got size %0d required 2 with 201", desc_log.size());
    end
    checks++;
    if (o_err !== 3'b011) begin
      errors++; $display("FAIL long_err: got %b required 011", o_err);
    end
    pix(pv(5000), 1'b0, 1'b0);
    wait_cyc(2);
    checks++;
    if (wr_log.size() !== 741 || {wr_log[740].ch, wr_log[740].addr} !== {1'b0, 12'h400}) begin
      errors++; $display("FAIL long_next_row: got size %0d required ch0 addr 400", wr_log.size());
    end
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    #1;
    checks++;
    if (o_err !== 3'b000) begin
      errors++; $display("FAIL err_clear: got %b required 000", o_err);
    end
  endtask

  task automatic test_credit_edges();
    do_reset();
    i_8row_free = 1'b1; i_err_clr = 1'b1;
    @(negedge clk);
    i_8row_free = 1'b0; i_err_clr = 1'b0;
    #1;
    checks++;
    if (dut.credit_q !== 4'd8 || o_err !== 3'b100) begin
      errors++; $display("FAIL credit_ovf: got credit %0d err %b required 8/100", dut.credit_q, o_err);
    end
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    i_8row_free = 1'b1;
    pix(pv(0), 1'b1, 1'b0);
    i_8row_free = 1'b0;
    #1;
    checks++;
    if (dut.credit_q !== 4'd8 || o_err !== 3'b000) begin
      errors++; $display("FAIL credit_sof_claim_free: got credit %0d err %b required 8/000", dut.credit_q, o_err);
    end
    pix(pv(1), 1'b0, 1'b1);
    pulse_free();
    #1;
    checks++;
    if (dut.credit_q !== 4'd8 || o_err !== 3'b001 || dut.state_q !== dut.S_LINE) begin
      errors++; $display("FAIL credit_commit_claim_free: got credit %0d err %b required 8/001 in LINE", dut.credit_q, o_err);
    end
  endtask

  task automatic test_sof_abort();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      pix(pv(r), r == 0, 1'b0);
      pix(pv(r + 10), 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) pix(pv(100 + i), 1'b0, 1'b0);
    pix(pv(200), 1'b1, 1'b0);
    pix(pv(201), 1'b0, 1'b0);
    pix(pv(202), 1'b0, 1'b1);
    wait_cyc(3);
    checks++;
    if (desc_log.size() !== 4) begin
      errors++; $display("FAIL abort_desc_count: got %0d required 4", desc_log.size());
    end else begin
      checks++;
      if (desc_log[3] !== {3'd3, 9'd0} || desc_log[2] !== {3'd2, 9'd2}) begin
        errors++; $display("FAIL abort_desc_data: got %h,%h required 402,600", desc_log[2], desc_log[3]);
      end
    end
    checks++;
    if (wr_log.size() < 14 || {wr_log[11].ch, wr_log[11].addr, wr_log[11].data} !== {1'b1, 12'h400, 8'h00, pv(200)}
        || wr_log[12].addr !== 12'h401) begin
      errors++; $display("FAIL abort_restart_write: got size %0d required sof pixel at ch1 addr 400", wr_log.size());
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 10; i++) pix(pv(i), i == 0, 1'b0);
    i_pix_vld = 1'b1; i_pix_data = pv(10);
    #1;
    checks++;
    if (o_ch0_we !== 1'b1) begin
      errors++; $display("FAIL midreset_pre_we: got %b required 1", o_ch0_we);
    end
    frst_n = 1'b0;
    #1;
    checks++;
    if ({o_pix_rdy, o_ch0_waddr, o_ch0_wdata, o_ch0_we, o_ch1_waddr, o_ch1_wdata,
         o_ch1_we, o_8row_wdata, o_8row_we, o_frame_done, o_err} !== '0) begin
      errors++; $display("FAIL midreset_outputs: some output nonzero, required all 0");
    end
    checks++;
    if (dut.credit_q !== 4'd8) begin
      errors++; $display("FAIL midreset_credit: got %0d required 8", dut.credit_q);
    end
    i_pix_vld = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_full_frame();
    test_no_free();
    test_fifo_full();
    test_short_long();
    test_credit_edges();
    test_sof_abort();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/img_line_writer.md
Name: img_line_writer

Overview:
- Write side of the 8-row image line buffer that feeds the HDMI resize reader.
- Accepts a 24-bit RGB pixel stream from the camera path and writes each image row into one of 8 row slots held in two BRAM channels: ch0 holds rows 0/2/4/6, ch1 holds rows 1/3/5/7.
- After a row is fully written, pushes a {row_id, row_h} descriptor into the 8-row FIFO.
- Uses a credit counter so it never overwrites a slot the reader still holds.

Parameters:
- IMG_W, 640, pixels per image row; BRAM column address range is 0..IMG_W-1, maximum 1024.
- IMG_H, 480, rows per frame; row_h range is 0..IMG_H-1, maximum 512.

Ports:
- clk  in  1  single clock domain.
- frst_n  in  1  asynchronous, active-low reset.
- i_pix_data  in  24  pixel {R,G,B}.
- i_pix_vld  in  1  pixel valid.
- i_pix_sof  in  1  qualifies the first pixel of a frame.
- i_pix_eol  in  1  qualifies the last pixel of a row.
- o_pix_rdy  out  1  pixel accepted when i_pix_vld & o_pix_rdy.
- o_ch0_waddr  out  12  {slot pair index = row_id[2:1], 10-bit column}.
- o_ch0_wdata  out  32  {8'h00, RGB}.
- o_ch0_we  out  1  ch0 write enable.
- o_ch1_waddr  out  12  same layout as ch0.
- o_ch1_wdata  out  32  same layout as ch0.
- o_ch1_we  out  1  ch1 write enable.
- o_8row_wdata  out  12  {row_id[2:0], row_h[8:0]}.
- o_8row_we  out  1  descriptor push.
- i_8row_full  in  1  8-row FIFO full.
- i_8row_free  in  1  1-cycle pulse, one slot released; driven by the reader's 8-row FIFO pop.
- i_err_clr  in  1  clears the sticky error flags.
- o_frame_done  out  1  1-cycle pulse after the last row descriptor of a frame is pushed.
- o_err  out  3  sticky flags {credit_ovf, long_row, short_row}.

Behaviour:
- Reset (frst_n=0, asynchronous): state IDLE, credit=8, row_id=0, row_h=0, col=0, and every output at 0.
- Credit counter, 4 bits, range 0..8:
  - Decremented in the cycle a transition into LINE occurs (slot claimed).
  - Incremented on i_8row_free.
  - If both happen in the same cycle, the count is unchanged.
  - i_8row_free while credit==8 and no claim: credit holds at 8 and sets o_err[2].
- States:
  - IDLE:
    - o_pix_rdy = ~i_pix_sof | (credit!=0).
    - Accepted non-SOF pixels are discarded.
    - An accepted SOF pixel sets row_h=0 and col=0, is written as column 0, and moves the block to LINE (claims a credit).
  - LINE:
    - o_pix_rdy=1.
    - Each accepted pixel is written at column col, then col increments.
    - Channel select is row_id[0]: 0 drives ch0, 1 drives ch1.
    - Accepted pixel with i_pix_eol, or accepted pixel at col==IMG_W-1: go to COMMIT.
    - i_pix_eol with col<IMG_W-1 sets o_err[0]; the row is still committed, and unwritten columns keep stale data.
    - An accepted i_pix_sof in LINE aborts the current row: no descriptor is pushed, the slot stays claimed and is reused, row_h=0, and that pixel is written as column 0.
  - COMMIT:
    - o_pix_rdy=0.
    - If ~i_8row_full, drive o_8row_we=1 with {row_id,row_h}, advance row_id (3-bit wrap 7 to 0), and set col=0.
    - If row_h==IMG_H-1: pulse o_frame_done and go to IDLE.
    - Otherwise: row_h+1; go to LINE if credit (after this cycle's update) !=0, else WAIT_SLOT.
  - WAIT_SLOT:
    - o_pix_rdy=0.
    - Go to LINE when credit!=0 (claims it).
- A pixel arriving at col==IMG_W-1 without eol commits the row. The following pixels that carry neither SOF nor EOL up to the next EOL are dropped with rdy=1 and set o_err[1]. The row after that starts on the next accepted pixel after that EOL.
- BRAM write timing: registered, 1 cycle after pixel acceptance; waddr/wdata are valid only with we.
- Descriptor push occurs no earlier than 1 cycle after the row's last BRAM write, so the data is in BRAM before the descriptor is visible to the reader.
- o_err is cleared by i_err_clr; a set event in the same cycle as i_err_clr wins.

Test Plan:
- Reset, then SOF followed by 640 contiguous pixels with eol on the last:
  - 640 ch0 writes at addr 0x000..0x27F.
  - Then o_8row_wdata={3'd0,9'd0}, one push.
  - credit=7; rdy low for exactly 1 cycle (COMMIT).
- Full 480-row frame with the reader freeing 1 slot per row after an 8-row delay:
  - row_id sequence 0..7 wraps.
  - Row 1 goes to ch1 at addr 0x000, row 2 to ch0 at 0x400, row 7 to ch1 at 0xC00.
  - Last descriptor is {row_id 7, 9'd479}; o_frame_done pulses once.
- No i_8row_free for 9 rows:
  - After the 8th descriptor, state is WAIT_SLOT and o_pix_rdy=0.
  - A single free pulse resumes exactly one row.
- i_8row_full held 5 cycles at commit:
  - o_8row_we delayed 5 cycles, no descriptor lost, rdy stays low meanwhile.
- Short row (eol at column 99) sets o_err[0] and still pushes a descriptor; long row (700 pixels before eol) pushes at column 639, drops 60 pixels, and sets o_err[1].
- Edge and mid-operation events:
  - i_8row_free coincident with a LINE claim leaves credit unchanged.
  - SOF in mid-row 3 restarts at row_h=0 with no descriptor pushed for the aborted row.
  - frst_n asserted mid-row returns all outputs to 0 immediately and credit to 8.
